// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin front end that lets NumPorts clients share the
// single read/write command port of sdram_ctrl. One command is in flight at a
// time; command spacing and read-data capture are timed by fixed counters
// because the controller offers no handshake.
module sdram_arbiter #(
  parameter int NumPorts   = 2,
  parameter int AddrWidth  = 13,
  parameter int DataWidth  = 16,
  parameter int BusyCycles = 6,
  parameter int RdLatency  = 3
) (
  input  logic                          i_sys_clk,
  input  logic                          i_rst_n,
  input  logic [NumPorts-1:0]           i_req,
  input  logic [NumPorts-1:0]           i_we,
  input  logic [NumPorts*AddrWidth-1:0] i_addr,
  input  logic [NumPorts*DataWidth-1:0] i_wdata,
  output logic [NumPorts-1:0]           o_ack,
  output logic [NumPorts-1:0]           o_rd_valid,
  output logic [DataWidth-1:0]          o_rd_data,
  output logic                          o_busy,
  output logic                          o_wr_req,
  output logic [AddrWidth-1:0]          o_wr_addr,
  output logic [DataWidth-1:0]          o_wr_data,
  output logic                          o_rd_req,
  output logic [AddrWidth-1:0]          o_rd_addr,
  input  logic [DataWidth-1:0]          i_rd_data
);

  localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int CW = (BusyCycles > 2) ? $clog2(BusyCycles) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         last_q, last_d;
  logic [PW-1:0]         g_q, g_d;
  logic [NumPorts-1:0]   ack_q, ack_d;
  logic [NumPorts-1:0]   rd_valid_q, rd_valid_d;
  logic                  wr_req_q, wr_req_d;
  logic                  rd_req_q, rd_req_d;
  logic                  busy_q, busy_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic [DataWidth-1:0]  rd_data_q, rd_data_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;

  logic                  any_req_s;
  logic [PW-1:0]         win_s;
  logic [PW-1:0]         cand_s;

  // Round-robin search: first requesting port after the last grant, wrapping.
  always_comb begin
    any_req_s = 1'b0;
    win_s     = last_q;
    cand_s    = last_q;
    for (int i = 1; i <= NumPorts; i++) begin
      cand_s = PW'((int'(last_q) + i) % NumPorts);
      if (!any_req_s && i_req[cand_s]) begin
        any_req_s = 1'b1;
        win_s     = cand_s;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  // Next-state logic for the arbitration FSM, command outputs and read capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    g_d        = g_q;
    ack_d      = '0;
    rd_valid_d = '0;
    wr_req_d   = 1'b0;
    rd_req_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_pend_d  = rd_pend_q;
    rd_cnt_d   = rd_cnt_q;

    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d       = ISSUE;
          g_d           = win_s;
          ack_d[win_s]  = 1'b1;
          wr_req_d      = i_we[win_s];
          rd_req_d      = ~i_we[win_s];
          addr_d        = i_addr[int'(win_s)*AddrWidth +: AddrWidth];
          wdata_d       = i_wdata[int'(win_s)*DataWidth +: DataWidth];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = BUSY;
        last_d  = g_q;
        cnt_d   = CW'(BusyCycles - 2);
        if (rd_req_q) begin
          rd_pend_d = 1'b1;
          rd_cnt_d  = CW'(RdLatency - 1);
        end else begin
          rd_pend_d = rd_pend_q;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The read pipeline runs independently of the FSM once the read is issued.
    if (rd_pend_q) begin
      if (rd_cnt_q == '0) begin
        rd_pend_d      = 1'b0;
        rd_data_d      = i_rd_data;
        rd_valid_d[g_q] = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q - CW'(1);
      end
    end else begin
      rd_cnt_d = rd_cnt_d;
    end

    busy_d = (state_d != IDLE);
  end

  // All state and outputs are registered; reset clears everything and
  // parks the pointer on the last port so port 0 wins first.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= PW'(NumPorts - 1);
      g_q        <= '0;
      ack_q      <= '0;
      rd_valid_q <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      g_q        <= g_d;
      ack_q      <= ack_d;
      rd_valid_q <= rd_valid_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_pend_q  <= rd_pend_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_busy     = busy_q;
  assign o_wr_req   = wr_req_q;
  assign o_wr_addr  = addr_q;
  assign o_wr_data  = wdata_q;
  assign o_rd_req   = rd_req_q;
  assign o_rd_addr  = addr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter. A transaction-level model decides, from
// the held client requests, which port the arbiter serves and when, and pushes
// the expected issue and read-return events; a monitor compares them against
// what the DUT presents.
module tb_sdram_arbiter;
  localparam int NP = 2;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int BC = 6;
  localparam int RL = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     i_req, i_we;
  logic [NP*AW-1:0]  i_addr;
  logic [NP*DW-1:0]  i_wdata;
  logic [DW-1:0]     i_rd_data;
  logic [NP-1:0]     o_ack, o_rd_valid;
  logic [DW-1:0]     o_rd_data, o_wr_data;
  logic              o_busy, o_wr_req, o_rd_req;
  logic [AW-1:0]     o_wr_addr, o_rd_addr;

  sdram_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW),
                  .BusyCycles(BC), .RdLatency(RL)) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ack(o_ack), .o_rd_valid(o_rd_valid),
    .o_rd_data(o_rd_data), .o_busy(o_busy), .o_wr_req(o_wr_req),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_rd_req(o_rd_req),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data));

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdv;
  } req_t;

  typedef struct {
    int            cyc;
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  req_t          pq[$];
  exp_t          iq[$];
  exp_t          rq[$];
  bit            exp_busy[int];
  logic [DW-1:0] ctrl_data[int];
  bit            hold[NP];
  bit            served[NP];
  req_t          cur[NP];
  int            cyc = 0;
  int            nf = 0;
  int            mlast = NP - 1;
  int            last_rd_issue = -1;
  logic [DW-1:0] exp_rd_data = '0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rv);
    req_t r;
    r.port = p; r.we = we; r.addr = a; r.wdata = wd; r.rdv = rv;
    pq.push_back(r);
  endtask

  task automatic push_rand(input int p);
    push(p, 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
  endtask

  // Client update for the current cycle followed by one step of the model.
  task automatic step();
    int   win;
    bit   found;
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      if (served[p]) begin hold[p] = 1'b0; served[p] = 1'b0; end
    end
    for (int p = 0; p < NP; p++) begin
      if (!hold[p]) begin
        for (int i = 0; i < pq.size(); i++) begin
          if (pq[i].port == p) begin
            cur[p] = pq[i]; pq.delete(i); hold[p] = 1'b1; break;
          end
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      i_req[p] = hold[p];
      i_we[p]  = hold[p] ? cur[p].we : 1'($urandom);
      i_addr[p*AW +: AW]  = hold[p] ? cur[p].addr : AW'($urandom);
      i_wdata[p*DW +: DW] = hold[p] ? cur[p].wdata : DW'($urandom);
    end
    if (cyc >= nf) begin
      found = 1'b0; win = 0;
      for (int k = 1; k <= NP; k++) begin
        if (!found && hold[(mlast + k) % NP]) begin
          found = 1'b1; win = (mlast + k) % NP;
        end
      end
      if (found) begin
        e.cyc = cyc + 1; e.port = win; e.we = cur[win].we;
        e.addr = cur[win].addr; e.data = cur[win].wdata;
        iq.push_back(e);
        if (!cur[win].we) begin
          ctrl_data[cyc + 1 + RL] = cur[win].rdv;
          e.cyc = cyc + 2 + RL; e.data = cur[win].rdv;
          rq.push_back(e);
          last_rd_issue = cyc + 1;
        end
        for (int b = 1; b <= BC; b++) exp_busy[cyc + b] = 1'b1;
        mlast = win; served[win] = 1'b1; nf = cyc + 1 + BC;
      end else begin
        nf = cyc + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    i_rd_data = ctrl_data.exists(cyc) ? ctrl_data[cyc] : DW'($urandom);
    if (rst_n) step();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((pq.size() > 0 || hold[0] || hold[1] || iq.size() > 0 || rq.size() > 0)
           && n < limit) begin
      tick(); n++;
    end
    n_tests++;
    if (n >= limit) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d cycles, %0d issues and %0d reads outstanding",
               n, iq.size(), rq.size());
    end
  endtask

  task automatic do_reset_clear();
    rst_n = 1'b0;
    pq.delete(); iq.delete(); rq.delete(); exp_busy.delete(); ctrl_data.delete();
    for (int p = 0; p < NP; p++) begin hold[p] = 1'b0; served[p] = 1'b0; end
    i_req = '0; mlast = NP - 1; exp_rd_data = '0;
  endtask

  // Monitor: compares every cycle's outputs against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_ctl", {o_ack, o_rd_valid, o_busy, o_wr_req, o_rd_req}, 32'd0);
        chk("reset_addr", {o_wr_addr, o_rd_addr}, 32'd0);
        chk("reset_data", {o_wr_data, o_rd_data}, 32'd0);
      end else begin
        chk("busy", o_busy, exp_busy.exists(cyc));
        while (iq.size() > 0 && iq[0].cyc < cyc) begin
          e = iq.pop_front();
          chk("issue_missing_cycle", 32'hFFFFFFFF, e.cyc);
        end
        if (o_ack != '0 || o_wr_req || o_rd_req) begin
          if (iq.size() == 0) begin
            chk("unexpected_issue_ack", o_ack, 32'd0);
          end else begin
            e = iq.pop_front();
            chk("issue_cycle", cyc, e.cyc);
            chk("ack", o_ack, 32'd1 << e.port);
            chk("wr_req", o_wr_req, e.we);
            chk("rd_req", o_rd_req, !e.we);
            if (e.we) begin
              chk("wr_addr", o_wr_addr, e.addr);
              chk("wr_data", o_wr_data, e.data);
            end else begin
              chk("rd_addr", o_rd_addr, e.addr);
            end
          end
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
          e = rq.pop_front();
          chk("rd_valid_missing_cycle", 32'hFFFFFFFF, e.cyc);
        end
        if (o_rd_valid != '0) begin
          if (rq.size() == 0) begin
            chk("unexpected_rd_valid", o_rd_valid, 32'd0);
          end else begin
            e = rq.pop_front();
            chk("rd_valid_cycle", cyc, e.cyc);
            chk("rd_valid_port", o_rd_valid, 32'd1 << e.port);
            exp_rd_data = e.data;
          end
        end
        chk("rd_data", o_rd_data, exp_rd_data);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int n;
    rst_n = 1'b1; i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0; i_rd_data = '0;
    #2;
    do_reset_clear();
    repeat (4) tick();
    rst_n = 1'b1; nf = cyc; step();
    repeat (8) tick();

    push(0, 1'b1, 13'h0123, 16'hBEEF, 16'h0000);
    drain(40);
    push(1, 1'b0, 13'h0456, 16'h0000, 16'hA5A5);
    drain(40);

    for (int i = 0; i < 4; i++) begin push_rand(0); push_rand(1); end
    drain(100);
    for (int i = 0; i < 3; i++) push_rand(1);
    drain(60);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0 && pq.size() < 4) push_rand(int'($urandom_range(NP - 1)));
      tick();
    end
    drain(200);

    last_rd_issue = -1;
    push(0, 1'b0, 13'h0777, 16'h0000, 16'h1234);
    n = 0;
    while (last_rd_issue < 0 && n < 50) begin tick(); n++; end
    chk("mid_reset_read_scheduled", (last_rd_issue >= 0), 32'd1);
    while (cyc < last_rd_issue + 2 && n < 100) begin tick(); n++; end
    do_reset_clear();
    tick(); tick();
    rst_n = 1'b1; nf = cyc;
    push(0, 1'b1, 13'h0111, 16'h1111, 16'h0000);
    push(1, 1'b1, 13'h0222, 16'h2222, 16'h0000);
    push(0, 1'b0, 13'h0333, 16'h0000, 16'h3333);
    push(1, 1'b0, 13'h0444, 16'h0000, 16'h4444);
    step();
    drain(80);
    repeat (3) tick();
    chk("queues_empty", iq.size() + rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
